ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, ALU result and store-data width.
- RADDR_W, 5, destination register index width.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i  in  1  pipeline clock.
- rst_i  in  1  synchronous active-high reset.
- stall_i  in  1  MEM stage busy; hold all outputs.
- flush_i  in  1  squash EX-stage instruction; insert bubble.
- valid_i  in  1  EX stage holds a real instruction.
- alu_result_i  in  DATA_W  ALU data_o of the current EX instruction.
- rs2_data_i  in  DATA_W  forwarded store data.
- rd_addr_i  in  RADDR_W  destination register.
- reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i  in  1 each  control bits.
- valid_o  out  1  MEM stage holds a real instruction.
- alu_result_o, rs2_data_o  out  DATA_W  registered copies.
- rd_addr_o  out  RADDR_W  registered copy.
- reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o  out  1 each  registered control bits, gated by valid.
- retired_cnt_o, bubble_cnt_o  out  32 each  performance counters; present only with EXMEM_PERF_CNT_EN.

Function
REQ-004 Each rising clk_i edge SHALL apply exactly one action, in priority order: rst_i, then flush_i, then stall_i, then load.
REQ-005 On load, all outputs SHALL take their _i values with 1-cycle latency, and valid_o SHALL take valid_i.
REQ-006 When valid_i=0 on load, reg_write_o, mem_read_o and mem_write_o SHALL be 0. Data fields are don't-care but SHALL still be captured.
REQ-007 On flush_i=1 without rst_i, valid_o and all four control outputs SHALL become 0 whatever stall_i is. Data fields SHALL hold their previous values.
REQ-008 On stall_i=1 without flush_i or rst_i, every output SHALL hold its value. The EX-side input is not consumed.
REQ-009 No output SHALL depend combinationally on any input; every output is a register.
REQ-010 Control outputs SHALL never be 1 while valid_o=0.

Reset
REQ-011 While rst_i=1 at a clock edge, valid_o, all control outputs, alu_result_o, rs2_data_o and rd_addr_o SHALL become 0. Counters SHALL become 0 when present.
REQ-012 Reset asserted during a stall or flush SHALL win, and the next cycle SHALL start from the reset state.

Configuration
REQ-013 With macro EXMEM_PERF_CNT_EN defined:
- retired_cnt_o SHALL increment on each load edge with valid_i=1.
- bubble_cnt_o SHALL increment on each load edge with valid_i=0 and on each flush edge.
- Stall edges SHALL increment neither counter.
- Both counters SHALL saturate at 0xFFFF_FFFF.
REQ-014 Without EXMEM_PERF_CNT_EN, the two counter ports and all counter logic SHALL be absent. All other behaviour is unchanged.

Structure
REQ-015 A shared package cpu_pkg SHALL hold:
- the DATA_W and RADDR_W defaults;
- the ALU control code constants;
- a packed typedef mem_ctrl_t bundling reg_write, mem_to_reg, mem_read and mem_write.
REQ-016 Counter logic SHALL live in one sub-module, sat_counter (32-bit, inc_i, clr_i, cnt_o), instantiated twice under EXMEM_PERF_CNT_EN.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset: rst_i=1 for 2 cycles with all inputs at 1 -> every output 0, counters 0.
- Load: valid_i=1, alu_result_i=0x0000_0010, rd_addr_i=5, reg_write_i=1 -> next cycle valid_o=1, alu_result_o=0x10, rd_addr_o=5, reg_write_o=1, retired_cnt_o=1.
- Stall: stall_i=1 for 3 cycles while inputs change to 0xDEAD_BEEF -> outputs hold 0x10; counters unchanged.
- Flush over stall: flush_i=1 and stall_i=1 together -> valid_o=0, all controls 0, bubble_cnt_o increments by 1.
- Bubble: valid_i=0 with mem_write_i=1 -> mem_write_o=0, valid_o=0.
- Saturation: counter preloaded by force to 0xFFFF_FFFE, then 3 valid loads -> retired_cnt_o=0xFFFF_FFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU control codes, MEM-stage control bundle
// and the per-edge action decode used by the EX/MEM pipeline register.
package cpu_pkg;

    localparam int CPU_DATA_W  = 32;
    localparam int CPU_RADDR_W = 5;
    localparam int PERF_CNT_W  = 32;

    // ALU control codes driven by the decoder into the EX stage.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    localparam mem_ctrl_t MEM_CTRL_NOP = '{default: 1'b0};

    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_STALL,
        ACT_LOAD
    } pipe_act_e;

    // Exactly one action per edge; earlier terms win.
    function automatic pipe_act_e pipe_action(input logic rst, input logic flush,
                                              input logic stall);
        pipe_act_e act;
        if (rst) begin
            act = ACT_RESET;
        end else if (flush) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_STALL;
        end else begin
            act = ACT_LOAD;
        end
        return act;
    endfunction

    // A bubble never carries live control bits into MEM.
    function automatic mem_ctrl_t gate_ctrl(input mem_ctrl_t ctrl, input logic valid);
        return valid ? ctrl : MEM_CTRL_NOP;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with reset > flush > stall > load priority.
// Optional performance counters are built when EXMEM_PERF_CNT_EN is defined.
module ex_mem_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W  = CPU_DATA_W,
    parameter int RADDR_W = CPU_RADDR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  alu_result_i,
    input  logic [DATA_W-1:0]  rs2_data_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic               reg_write_i,
    input  logic               mem_to_reg_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    output logic               valid_o,
    output logic [DATA_W-1:0]  alu_result_o,
    output logic [DATA_W-1:0]  rs2_data_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               reg_write_o,
    output logic               mem_to_reg_o,
    output logic               mem_read_o,
    output logic               mem_write_o
`ifdef EXMEM_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] retired_cnt_o,
    output logic [PERF_CNT_W-1:0] bubble_cnt_o
`endif
);

    pipe_act_e          act;
    mem_ctrl_t          ctrl_in;

    logic               valid_d,  valid_q;
    mem_ctrl_t          ctrl_d,   ctrl_q;
    logic [DATA_W-1:0]  alu_d,    alu_q;
    logic [DATA_W-1:0]  rs2_d,    rs2_q;
    logic [RADDR_W-1:0] rd_d,     rd_q;

    assign act     = pipe_action(rst_i, flush_i, stall_i);
    assign ctrl_in = '{reg_write:  reg_write_i,
                       mem_to_reg: mem_to_reg_i,
                       mem_read:   mem_read_i,
                       mem_write:  mem_write_i};

    // NOTE: every _d is given its hold value first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        unique case (act)
            ACT_RESET: begin
                valid_d = 1'b0;
                ctrl_d  = MEM_CTRL_NOP;
                alu_d   = '0;
                rs2_d   = '0;
                rd_d    = '0;
            end
            ACT_FLUSH: begin
                // Data fields deliberately keep their old contents.
                valid_d = 1'b0;
                ctrl_d  = MEM_CTRL_NOP;
            end
            ACT_STALL: begin
            end
            ACT_LOAD: begin
                valid_d = valid_i;
                ctrl_d  = gate_ctrl(ctrl_in, valid_i);
                alu_d   = alu_result_i;
                rs2_d   = rs2_data_i;
                rd_d    = rd_addr_i;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    // NOTE: the data registers are reset too, so MEM never sees X on the bus
    // after power-up, even though valid_o already marks them as dead.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= MEM_CTRL_NOP;
            alu_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
        end
    end

    assign valid_o      = valid_q;
    assign alu_result_o = alu_q;
    assign rs2_data_o   = rs2_q;
    assign rd_addr_o    = rd_q;
    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign mem_read_o   = ctrl_q.mem_read;
    assign mem_write_o  = ctrl_q.mem_write;

`ifdef EXMEM_PERF_CNT_EN
    logic retired_inc;
    logic bubble_inc;

    // A flush edge inserts a bubble even when the EX instruction was valid.
    assign retired_inc = (act == ACT_LOAD) &&  valid_i;
    assign bubble_inc  = ((act == ACT_LOAD) && !valid_i) || (act == ACT_FLUSH);

    sat_counter #(
        .W (PERF_CNT_W)
    ) u_retired_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (retired_inc),
        .clr_i (1'b0),
        .cnt_o (retired_cnt_o)
    );

    sat_counter #(
        .W (PERF_CNT_W)
    ) u_bubble_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (bubble_inc),
        .clr_i (1'b0),
        .cnt_o (bubble_cnt_o)
    );
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: a reference model predicts each edge, the
// prediction is queued, then popped and compared just after the edge.
module tb_ex_mem_reg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               stall_i;
    logic               flush_i;
    logic               valid_i;
    logic [DATA_W-1:0]  alu_result_i;
    logic [DATA_W-1:0]  rs2_data_i;
    logic [RADDR_W-1:0] rd_addr_i;
    logic               reg_write_i;
    logic               mem_to_reg_i;
    logic               mem_read_i;
    logic               mem_write_i;
    logic               valid_o;
    logic [DATA_W-1:0]  alu_result_o;
    logic [DATA_W-1:0]  rs2_data_o;
    logic [RADDR_W-1:0] rd_addr_o;
    logic               reg_write_o;
    logic               mem_to_reg_o;
    logic               mem_read_o;
    logic               mem_write_o;
`ifdef EXMEM_PERF_CNT_EN
    logic [31:0]        retired_cnt_o;
    logic [31:0]        bubble_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    ex_mem_reg #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .alu_result_i (alu_result_i),
        .rs2_data_i   (rs2_data_i),
        .rd_addr_i    (rd_addr_i),
        .reg_write_i  (reg_write_i),
        .mem_to_reg_i (mem_to_reg_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .valid_o      (valid_o),
        .alu_result_o (alu_result_o),
        .rs2_data_o   (rs2_data_o),
        .rd_addr_o    (rd_addr_o),
        .reg_write_o  (reg_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o)
`ifdef EXMEM_PERF_CNT_EN
        ,
        .retired_cnt_o (retired_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o)
`endif
    );

    typedef struct packed {
        logic               valid;
        logic [3:0]         ctrl;   // reg_write, mem_to_reg, mem_read, mem_write
        logic [DATA_W-1:0]  alu;
        logic [DATA_W-1:0]  rs2;
        logic [RADDR_W-1:0] rd;
        logic [31:0]        retired;
        logic [31:0]        bubble;
    } exp_t;

    exp_t model = '0;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Reference behaviour for one rising edge given the current inputs.
    function automatic void model_edge();
        if (rst_i) begin
            model = '0;
        end else if (flush_i) begin
            model.valid  = 1'b0;
            model.ctrl   = 4'b0000;
            model.bubble = sat_inc(model.bubble);
        end else if (!stall_i) begin
            model.valid = valid_i;
            model.ctrl  = valid_i ? {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i}
                                  : 4'b0000;
            model.alu   = alu_result_i;
            model.rs2   = rs2_data_i;
            model.rd    = rd_addr_i;
            if (valid_i) model.retired = sat_inc(model.retired);
            else         model.bubble  = sat_inc(model.bubble);
        end
    endfunction

    task automatic step(input string tag);
        exp_t e;
        model_edge();
        exp_q.push_back(model);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        check({tag, ".valid"}, {31'd0, valid_o}, {31'd0, e.valid});
        check({tag, ".ctrl"}, {28'd0, reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o},
              {28'd0, e.ctrl});
        check({tag, ".alu"}, alu_result_o, e.alu);
        check({tag, ".rs2"}, rs2_data_o, e.rs2);
        check({tag, ".rd"}, {27'd0, rd_addr_o}, {27'd0, e.rd});
`ifdef EXMEM_PERF_CNT_EN
        check({tag, ".retired"}, retired_cnt_o, e.retired);
        check({tag, ".bubble"}, bubble_cnt_o, e.bubble);
`endif
    endtask

    task automatic set_in(input logic rst, input logic stall, input logic flush,
                          input logic valid, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic [3:0] ctrl);
        rst_i        = rst;
        stall_i      = stall;
        flush_i      = flush;
        valid_i      = valid;
        alu_result_i = alu;
        rs2_data_i   = rs2;
        rd_addr_i    = rd;
        {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i} = ctrl;
    endtask

    initial begin
        // Reset with every input high: reset must beat flush and stall.
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 4'hF);
        step("reset0");
        step("reset1");

        // Plain load.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0022, 5'd5, 4'b1000);
        step("load");

        // Stall three cycles while the EX side changes underneath.
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd9, 4'b1111);
        for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i));

        // Flush together with stall: bubble inserted, data held.
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h8765_4321, 5'd7, 4'b1111);
        step("flush_stall");

        // Bubble load: data captured, controls gated.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 32'hCAFE_0002, 5'd3, 4'b0001);
        step("bubble");

        // Valid store then load-use pattern.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 5'd0, 4'b0001);
        step("store");
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 5'd12, 4'b1110);
        step("loadw");

        // Reset during stall must win.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h5555_5555, 32'h6666_6666, 5'd4, 4'b1111);
        step("rst_stall");
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00AA, 32'h0000_00BB, 5'd31, 4'b1100);
        step("after_rst");

        // Mixed random traffic.
        for (int i = 0; i < 40; i++) begin
            set_in(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
                   $urandom, $urandom, 5'($urandom), 4'($urandom));
            step($sformatf("rand%0d", i));
        end

`ifdef EXMEM_PERF_CNT_EN
        // Saturation of the retired counter.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'h0, 5'd1, 4'b1000);
        force dut.u_retired_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_retired_cnt.cnt_q;
        model.retired = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step($sformatf("sat%0d", i));
        check("sat_final", retired_cnt_o, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
